// File: rtl/exec_pkg.sv
// Shared types and sizing for the execute stage: opcode and FSM state encodings.
package exec_pkg;
  localparam int EXEC_DW   = 16;
  localparam int EXEC_AW   = 3;
  localparam int MUL_STEPS = 16;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_MOV = 4'd8,
    OP_MUL = 4'd9,
    OP_CMP = 4'd10
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;
endpackage

// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
// done is combinational on the final step and product then already includes it.
module mul_seq
  import exec_pkg::*;
#(
  parameter int DW = EXEC_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic            step,
  input  logic            kill,
  output logic            done,
  output logic [2*DW-1:0] product
);
  localparam int CW = $clog2(MUL_STEPS);
  localparam logic [CW-1:0] LAST = CW'(MUL_STEPS - 1);

  logic [2*DW-1:0] acc, mcand, acc_next;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = acc_next;
  assign done     = step && !kill && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{DW{1'b0}}, b};
      mplier <= a;
      cnt    <= '0;
    end else if (kill) begin
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU plus iterative MUL, driving the register file write port.
//   state  | meaning
//   S_IDLE | accepting ops; ALU results written back one edge after acceptance
//   S_MUL  | multiplier stepping, issue blocked until writeback or kill
module execute_unit
  import exec_pkg::*;
#(
  parameter int DW = EXEC_DW,
  parameter int AW = EXEC_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [3:0]    op,
  input  logic [AW-1:0] dst_addr,
  input  logic [DW-1:0] rd_in,
  input  logic [DW-1:0] rs_in,
  input  logic          kill,
  output logic [DW-1:0] result,
  output logic [AW-1:0] result_w,
  output logic          wr_en,
  output logic          flag_z,
  output logic          flag_c
);
  state_e state, state_next;
  logic accept, mul_start, mul_step, mul_done;
  logic [2*DW-1:0] product;
  logic [AW-1:0] mul_dst;
  logic [DW:0] sum;
  logic [DW-1:0] alu_res;
  logic alu_c, alu_wr, alu_fl;

  mul_seq #(.DW(DW)) u_mul (
    .clk(clk), .rst(rst), .start(mul_start), .a(rd_in), .b(rs_in),
    .step(mul_step), .kill(kill), .done(mul_done), .product(product)
  );

  always_comb begin
    state_next  = state;
    issue_ready = 1'b0;
    accept      = 1'b0;
    mul_start   = 1'b0;
    mul_step    = 1'b0;
    case (state)
      S_IDLE: begin
        issue_ready = rst & ~kill;
        accept      = issue_valid & issue_ready;
        if (accept && op == OP_MUL) begin
          mul_start  = 1'b1;
          state_next = S_MUL;
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (kill || mul_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign sum = {1'b0, rd_in} + {1'b0, rs_in};

  // alu_fl marks ops that update flags; CMP updates flags without writing.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_wr  = 1'b0;
    alu_fl  = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum[DW-1:0];     alu_c = sum[DW];        alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_SUB: begin alu_res = rd_in - rs_in;   alu_c = rd_in < rs_in;  alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_CMP: begin alu_res = rd_in - rs_in;   alu_c = rd_in < rs_in;                 alu_fl = 1'b1; end
      OP_AND: begin alu_res = rd_in & rs_in;   alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_OR:  begin alu_res = rd_in | rs_in;   alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_XOR: begin alu_res = rd_in ^ rs_in;   alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_SLL: begin alu_res = rd_in << rs_in[3:0]; alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_SRL: begin alu_res = rd_in >> rs_in[3:0]; alu_wr = 1'b1; alu_fl = 1'b1; end
      OP_MOV: begin alu_res = rs_in;           alu_wr = 1'b1; alu_fl = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      mul_dst <= '0;
    end else begin
      state <= state_next;
      if (mul_start) mul_dst <= dst_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result   <= '0;
      result_w <= '0;
      wr_en    <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (mul_done) begin
        result   <= product[DW-1:0];
        result_w <= mul_dst;
        wr_en    <= 1'b1;
        flag_z   <= (product[DW-1:0] == '0);
        flag_c   <= |product[2*DW-1:DW];
      end else if (accept && op != OP_MUL) begin
        if (alu_wr) begin
          result   <= alu_res;
          result_w <= dst_addr;
          wr_en    <= 1'b1;
        end
        if (alu_fl) begin
          flag_z <= (alu_res == '0);
          flag_c <= alu_c;
        end
      end
    end
  end
endmodule
